bin2bcd_seq: RTL

Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Generalises the fixed 4-bit combinational converter to any input width.
- Adds optional signed (two's-complement) input handling.
- Uses a start/done handshake so the block can be dropped between a datapath register and a display or UART formatter.
- Cost is one iteration per input bit instead of a wide combinational tree.

---
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One iteration per input bit, with a start/ready/done handshake and optional signed input.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [WIDTH-1:0]             bin,
   output logic                         ready,
   output logic                         busy,
   output logic                         done,
   output logic [4*((WIDTH+2)/3)-1:0]   bcd,
   output logic                         neg
);

   localparam int DIGITS    = (WIDTH + 2) / 3;
   localparam int SW        = 4 * DIGITS;
   localparam int CW        = $clog2(WIDTH + 1);
   localparam bit IS_SIGNED = (SIGNED != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shift_reg;
   logic [SW-1:0]    scratch;
   logic [SW-1:0]    scratch_adj;
   logic [SW-1:0]    scratch_shifted;
   logic [CW-1:0]    counter;
   logic             pending_neg;
   logic [WIDTH-1:0] magnitude;
   logic             is_neg;
   logic             last_iter;

   // The most negative operand negates to itself, which read unsigned is exactly its magnitude.
   always_comb begin
      magnitude = bin;
      is_neg    = 1'b0;
      if (IS_SIGNED && bin[WIDTH-1]) begin
         magnitude = (~bin) + {{(WIDTH-1){1'b0}}, 1'b1};
         is_neg    = 1'b1;
      end
   end

   always_comb begin
      scratch_adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) begin
            scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         end
      end
      scratch_shifted = {scratch_adj[SW-2:0], shift_reg[WIDTH-1]};
   end

   assign last_iter = (counter == CW'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE);
      busy  = (state == SHIFT) || (state == DONE);
      done  = (state == DONE);
   end

   // Results are only written on the final iteration so bcd never exposes partial scratch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_reg   <= '0;
         scratch     <= '0;
         counter     <= '0;
         pending_neg <= 1'b0;
         bcd         <= '0;
         neg         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg   <= magnitude;
                  scratch     <= '0;
                  pending_neg <= is_neg;
                  counter     <= CW'(WIDTH);
               end
            end
            SHIFT: begin
               scratch   <= scratch_shifted;
               shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
               counter   <= counter - CW'(1);
               if (last_iter) begin
                  bcd <= scratch_shifted;
                  neg <= pending_neg;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
